awmc_panel: RTL and testbench
=============================

Name: awmc_panel

Overview:
- Operator-panel front end for the washing-machine controller; drives its `start`/`pause` inputs and consumes its `stage`/`done` outputs.
- Debounces the raw start/pause buttons, sequences the run/pause/resume handshake, and drives stage LEDs, pause indicator, door lock, buzzer and fault flag.
- Sits between the board I/O and the controller instance, in the same clock domain.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples needed to accept a button level change.
- BUZZ_CYCLES, 8, buzzer-on duration after cycle completion.
- BLINK_HALF, 4, half-period in cycles of the paused-stage LED blink.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- btn_start  in  1  raw start button, asynchronous, active-high.
- btn_pause  in  1  raw pause button, asynchronous, active-high.
- stage_in  in  3  controller stage: 0..4 = active stage, 3'b111 = idle/paused, 5..6 = illegal.
- done_in  in  1  controller completion flag.
- start  out  1  one-cycle start pulse to the controller.
- pause  out  1  pause level to the controller; held high for the whole pause.
- stage_led  out  5  one-hot stage display.
- paused_led  out  1  high when the pause has been acknowledged.
- door_lock  out  1  high while the drum must stay closed.
- buzzer  out  1  completion buzzer.
- fault  out  1  sticky illegal-stage flag.

Behaviour:
- Reset (reset==0 at a clk edge) clears all outputs to 0, FSM to IDLE, counters to 0, last_stage to 3'b111, synchronizer and debounced levels to 0. Reset mid-operation aborts immediately, with no pulse or buzzer emitted.
- Input path, per button:
  - 2-flop synchronizer.
  - Debounce counter: when the synced level differs from the debounced level for DEBOUNCE_CYCLES consecutive cycles, the debounced level updates; any mismatch gap resets the counter.
  - A press event is one cycle on the debounced 0->1 edge.
  - Raw-to-event latency is 2 + DEBOUNCE_CYCLES cycles. Release generates no event.
- FSM states: IDLE, RUNNING, PAUSE_REQ, PAUSED, FINISHED.
  - IDLE: start event -> start=1 for exactly one cycle (registered), then RUNNING. Pause event is ignored.
  - RUNNING:
    - pause event -> pause=1, go to PAUSE_REQ.
    - done_in==1 -> FINISHED, load the buzzer counter. done_in has priority over a same-cycle pause event.
    - start event is ignored.
  - PAUSE_REQ: pause stays 1. When stage_in==3'b111 -> PAUSED with paused_led=1. Other events are ignored.
  - PAUSED: start or pause event (either one or both in the same cycle) -> pause=0, go to RUNNING. No start pulse is issued, because the controller resumes on pause release.
  - FINISHED:
    - buzzer=1 for BUZZ_CYCLES cycles, then 0.
    - Remains in FINISHED until reset; all button events are ignored.
- pause output equals 1 exactly in PAUSE_REQ and PAUSED.
- door_lock = 1 in RUNNING and PAUSE_REQ, 0 elsewhere. The door unlocks only once the pause is acknowledged.
- last_stage register captures stage_in whenever stage_in <= 4.
- stage_led:
  - RUNNING / PAUSE_REQ: one-hot of last_stage (bit n for stage n); all 0 while last_stage == 3'b111.
  - PAUSED: same one-hot ANDed with a blink phase that toggles every BLINK_HALF cycles. The phase starts on (LEDs lit) on PAUSED entry.
  - IDLE / FINISHED: all 0.
- fault: set when stage_in is 5 or 6 in any non-IDLE state. It stays set until reset. The FSM does not react to it.
- All counters saturate or reload; there is no wrap-induced event.

Decomposition:
- Shared package:
  - FSM state typedef.
  - Stage encoding constants: STG_IDLE = 3'b111, STG_LAST = 3'd4.
  - Controller interface widths.
- One sub-module, awmc_debounce (synchronizer + debounce counter + rising-edge event), instantiated once per button.

Test Plan:
- Reset, then btn_start held high 10 cycles -> start is high exactly one cycle, 6 cycles after the press; state RUNNING; door_lock=1.
- btn_start glitch of 2 cycles high -> no start pulse; state stays IDLE.
- RUNNING at stage_in=2, pause pressed -> pause=1 and door_lock=1 until the model drives stage_in=3'b111 -> paused_led=1, door_lock=0, stage_led toggles 5'b00100 / 0 every 4 cycles.
- PAUSED, start and pause pressed in the same cycle -> one resume: pause=0, RUNNING, no start pulse.
- RUNNING, done_in=1 in the same cycle as a pause event -> FINISHED; buzzer high 8 cycles; pause stays 0; later start presses are ignored.
- stage_in=3'b101 while RUNNING -> fault=1 persists; reset low one cycle mid-PAUSED -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/awmc_panel_pkg.sv
// Shared types and constants for the washing-machine operator panel.
package awmc_panel_pkg;

  localparam int unsigned STAGE_W = 3;
  localparam int unsigned LED_W   = 5;

  localparam logic [STAGE_W-1:0] STG_IDLE = 3'b111;
  localparam logic [STAGE_W-1:0] STG_LAST = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUNNING,
    ST_PAUSE_REQ,
    ST_PAUSED,
    ST_FINISHED
  } state_t;

  // Stage codes above STG_LAST (idle or illegal) light nothing.
  function automatic logic [LED_W-1:0] stage_onehot(input logic [STAGE_W-1:0] s);
    logic [LED_W-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < LED_W; i++) begin
      oh[i] = (s == STAGE_W'(i));
    end
    return oh;
  endfunction

endpackage

// File: rtl/awmc_panel_debounce.sv
// Button front end: 2-flop synchronizer, debounce counter, one-cycle press event.
module awmc_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;
  logic          accept;

  // Accept fires in the cycle whose edge commits the new level, so the press
  // event lines up with the debounced 0->1 transition.
  assign accept = (sync2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign press  = accept && sync2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/awmc_panel.sv
// Operator panel: debounced buttons, run/pause/resume handshake and indicators.
module awmc_panel
  import awmc_panel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned BUZZ_CYCLES     = 8,
  parameter int unsigned BLINK_HALF      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_start,
  input  logic               btn_pause,
  input  logic [STAGE_W-1:0] stage_in,
  input  logic               done_in,
  output logic               start,
  output logic               pause,
  output logic [LED_W-1:0]   stage_led,
  output logic               paused_led,
  output logic               door_lock,
  output logic               buzzer,
  output logic               fault
);

  localparam int unsigned BZ_W = $clog2(BUZZ_CYCLES + 1);
  localparam int unsigned BL_W = $clog2(BLINK_HALF + 1);

  state_t             state, state_n;
  logic               start_n;
  logic               start_ev, pause_ev;
  logic [STAGE_W-1:0] last_stage;
  logic [BZ_W-1:0]    buzz_cnt;
  logic [BL_W-1:0]    blink_cnt;
  logic               blink_on;
  logic [LED_W-1:0]   stage_oh;

  awmc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_start),
    .press (start_ev)
  );

  awmc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_pause),
    .press (pause_ev)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      start <= 1'b0;
    end else begin
      state <= state_n;
      start <= start_n;
    end
  end

  // Blink phase is held "lit" outside PAUSED so it starts lit on entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_stage <= STG_IDLE;
      fault      <= 1'b0;
      buzz_cnt   <= '0;
      blink_cnt  <= '0;
      blink_on   <= 1'b0;
    end else begin
      if (stage_in <= STG_LAST) last_stage <= stage_in;
      if (state != ST_IDLE && stage_in > STG_LAST && stage_in != STG_IDLE) fault <= 1'b1;

      if (state == ST_RUNNING && done_in) begin
        buzz_cnt <= BZ_W'(BUZZ_CYCLES);
      end else if (state == ST_FINISHED && buzz_cnt != '0) begin
        buzz_cnt <= buzz_cnt - 1'b1;
      end

      if (state != ST_PAUSED) begin
        blink_on  <= 1'b1;
        blink_cnt <= '0;
      end else if (blink_cnt == BL_W'(BLINK_HALF - 1)) begin
        blink_on  <= ~blink_on;
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign stage_oh = stage_onehot(last_stage);

  always_comb begin
    state_n    = state;
    start_n    = 1'b0;
    pause      = 1'b0;
    door_lock  = 1'b0;
    paused_led = 1'b0;
    stage_led  = '0;
    buzzer     = (buzz_cnt != '0);
    case (state)
      ST_IDLE: begin
        if (start_ev) begin
          start_n = 1'b1;
          state_n = ST_RUNNING;
        end
      end
      ST_RUNNING: begin
        door_lock = 1'b1;
        stage_led = stage_oh;
        if (done_in)       state_n = ST_FINISHED;
        else if (pause_ev) state_n = ST_PAUSE_REQ;
      end
      ST_PAUSE_REQ: begin
        pause     = 1'b1;
        door_lock = 1'b1;
        stage_led = stage_oh;
        if (stage_in == STG_IDLE) state_n = ST_PAUSED;
      end
      ST_PAUSED: begin
        pause      = 1'b1;
        paused_led = 1'b1;
        stage_led  = blink_on ? stage_oh : '0;
        if (start_ev || pause_ev) state_n = ST_RUNNING;
      end
      ST_FINISHED: ;
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_awmc_panel.sv
// Scoreboard bench for awmc_panel against a window/timestamp reference model.
module tb_awmc_panel;

  localparam int unsigned DB = 4;
  localparam int unsigned BZ = 8;
  localparam int unsigned BH = 4;

  logic       clk = 1'b0;
  logic       reset, btn_start, btn_pause, done_in;
  logic [2:0] stage_in;
  logic       start, pause, paused_led, door_lock, buzzer, fault;
  logic [4:0] stage_led;

  always #5 clk = ~clk;

  awmc_panel #(.DEBOUNCE_CYCLES(DB), .BUZZ_CYCLES(BZ), .BLINK_HALF(BH)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_start  (btn_start),
    .btn_pause  (btn_pause),
    .stage_in   (stage_in),
    .done_in    (done_in),
    .start      (start),
    .pause      (pause),
    .stage_led  (stage_led),
    .paused_led (paused_led),
    .door_lock  (door_lock),
    .buzzer     (buzzer),
    .fault      (fault)
  );

  typedef struct packed {
    logic       start;
    logic       pause;
    logic [4:0] led;
    logic       pled;
    logic       lock;
    logic       buzz;
    logic       fault;
  } obs_t;

  obs_t        exp_q[$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: edge-indexed raw button history plus event timestamps.
  typedef enum {M_IDLE, M_RUN, M_PREQ, M_PAUSED, M_FIN} mstate_t;
  mstate_t     ms = M_IDLE;
  int          edge_n = 0, rst_edge = 0, fin_edge = 0, pz_edge = 0;
  bit          hs[0:4095];
  bit          hp[0:4095];
  bit          lvl_s = 0, lvl_p = 0, mfault = 0, m_start = 0;
  int unsigned mlast = 7;

  function automatic bit raw_at(bit which, int idx);
    if (idx <= rst_edge || idx < 0) return 1'b0;
    return which ? hp[idx] : hs[idx];
  endfunction

  // Level flips at edge m when the synchronized samples seen at the last DB
  // edges (raw taken two edges earlier) all disagree with the current level.
  function automatic bit window_flip(bit which, bit lvl, int m);
    for (int k = 2; k < int'(DB) + 2; k++)
      if (raw_at(which, m - k) == lvl) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [4:0] oh(int unsigned s);
    return (s <= 4) ? 5'(1 << s) : 5'd0;
  endfunction

  task automatic model_step();
    bit   sev, pev;
    obs_t e;
    edge_n++;
    hs[edge_n] = btn_start;
    hp[edge_n] = btn_pause;
    if (!reset) begin
      ms = M_IDLE; lvl_s = 0; lvl_p = 0; mlast = 7; mfault = 0; m_start = 0;
      rst_edge = edge_n; fin_edge = 0; pz_edge = 0;
    end else begin
      sev = 0; pev = 0;
      if (window_flip(0, lvl_s, edge_n)) begin lvl_s = !lvl_s; sev = lvl_s; end
      if (window_flip(1, lvl_p, edge_n)) begin lvl_p = !lvl_p; pev = lvl_p; end
      if (ms != M_IDLE && (stage_in == 3'd5 || stage_in == 3'd6)) mfault = 1;
      if (stage_in <= 3'd4) mlast = stage_in;
      m_start = 0;
      case (ms)
        M_IDLE:   if (sev) begin m_start = 1; ms = M_RUN; end
        M_RUN:    if (done_in) begin ms = M_FIN; fin_edge = edge_n; end
                  else if (pev) ms = M_PREQ;
        M_PREQ:   if (stage_in == 3'b111) begin ms = M_PAUSED; pz_edge = edge_n; end
        M_PAUSED: if (sev || pev) ms = M_RUN;
        default:  ;
      endcase
    end
    e.start = m_start;
    e.pause = (ms == M_PREQ || ms == M_PAUSED);
    e.pled  = (ms == M_PAUSED);
    e.lock  = (ms == M_RUN || ms == M_PREQ);
    e.buzz  = (ms == M_FIN) && (edge_n - fin_edge < int'(BZ));
    e.fault = mfault;
    if (ms == M_RUN || ms == M_PREQ) e.led = oh(mlast);
    else if (ms == M_PAUSED && ((edge_n - pz_edge) / int'(BH)) % 2 == 0) e.led = oh(mlast);
    else e.led = 5'd0;
    exp_q.push_back(e);
  endtask

  // Inputs are set at a falling edge; the model predicts the next rising edge.
  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rand_run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      stage_in = 3'($urandom_range(0, 4));
      tick();
    end
  endtask

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{start: start, pause: pause, led: stage_led, pled: paused_led,
              lock: door_lock, buzz: buzzer, fault: fault};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs t=%0t {start,pause,led,pled,lock,buzz,fault} got=%b want=%b",
                   $time, a, e);
        end
      end
    end
  end

  initial begin : driver
    reset = 0; btn_start = 0; btn_pause = 0; done_in = 0; stage_in = 3'b111;
    @(negedge clk);
    ticks(3);
    reset = 1;
    ticks(4);

    // short start glitch must not be accepted
    btn_start = 1; ticks($urandom_range(1, 2)); btn_start = 0;
    ticks(8);

    // real start press, then random stages and start noise while running
    btn_start = 1; ticks(10); btn_start = 0;
    rand_run_ticks(8);
    for (int i = 0; i < 20; i++) begin
      btn_start = 1'($urandom_range(0, 1));
      stage_in  = 3'($urandom_range(0, 4));
      tick();
    end
    btn_start = 0;
    rand_run_ticks(8);

    // pause at stage 2, acknowledge, watch the blink
    stage_in = 3'd2; ticks(2);
    btn_pause = 1; ticks(10); btn_pause = 0;
    ticks(3);
    stage_in = 3'b111;
    ticks(20);

    // simultaneous start+pause resumes once
    btn_start = 1; btn_pause = 1; ticks(10);
    btn_start = 0; btn_pause = 0;
    rand_run_ticks(8);
    stage_in = 3'd3; ticks(2);

    // illegal stage sets the sticky fault
    stage_in = 3'b101; tick();
    stage_in = 3'd3; ticks(4);

    // completion arrives on the same edge as the pause event
    btn_pause = 1;
    for (int i = 0; i < 10; i++) begin
      done_in = (i == int'(DB) + 1);
      tick();
    end
    done_in = 0; btn_pause = 0;
    ticks(4);
    btn_start = 1; ticks(10); btn_start = 0;
    ticks(8);

    // back to PAUSED, then a one-cycle reset
    reset = 0; tick(); reset = 1;
    stage_in = 3'b111;
    btn_start = 1; ticks(10); btn_start = 0;
    stage_in = 3'd1; ticks(4);
    btn_pause = 1; ticks(10); btn_pause = 0;
    stage_in = 3'b111; ticks(6);
    reset = 0; tick(); reset = 1;
    ticks(6);

    @(posedge clk); #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
